card_frame_buffer: RTL
======================

Name: card_frame_buffer

Overview:
- Double-buffered store of the ten on-screen card slots plus the win/loss flag, feeding the VGA controller's `RAMaddr` → `cardIndex` lookup and its `winLoss` input.
- The processor writes a shadow bank through a memory-mapped write port. The shadow bank is copied to the display bank only at frame boundary (`screenEnd`), so a hand update never tears mid-frame.
- A hardware clear sequencer blanks all slots for a new hand.

Parameters:
- NUM_SLOTS, 10, number of card slots (two rows of five).
- BASE_ADDR, 16, address of slot 0; slot n is at BASE_ADDR+n.
- WL_ADDR, 26, address of the win/loss register.
- CLEAR_ADDR, 27, address whose write starts a clear sequence.
- SPRITE_COUNT, 14, number of sprites in the card sheet; legal indices are 0..SPRITE_COUNT-1.
- BLANK_INDEX, 13, sprite index shown for an empty slot (card back).

Ports:
- clk  in  1  pixel/system clock (same clock as the VGA controller)
- reset  in  1  synchronous, active-high reset
- cpu_wEn  in  1  processor write strobe, one cycle per write
- cpu_addr  in  32  processor write address
- cpu_data  in  32  processor write data
- cpu_busy  out  1  high while a clear sequence runs; writes are dropped while high
- screenEnd  in  1  one-cycle frame-boundary pulse from the timing generator
- RAMaddr  in  32  slot read address from the VGA controller
- cardIndex  out  32  registered sprite index for RAMaddr
- winLoss  out  2  committed state: 00 none, 01 win, 10 loss
- commit_pending  out  1  shadow bank differs from display bank, awaiting screenEnd

Behaviour:
- Reset (synchronous, active-high) sets:
  - all shadow and display slots to BLANK_INDEX;
  - shadow and display winLoss to 00;
  - FSM to IDLE;
  - cpu_busy=0, commit_pending=0, cardIndex=BLANK_INDEX.
  - Reset asserted mid-clear or mid-commit aborts the operation and yields exactly these values on the next cycle.
- Write decode, IDLE only, when cpu_wEn=1:
  - cpu_addr in [BASE_ADDR, BASE_ADDR+NUM_SLOTS-1]:
    - shadow[cpu_addr-BASE_ADDR] takes cpu_data if cpu_data < SPRITE_COUNT, else BLANK_INDEX;
    - set commit_pending.
  - cpu_addr = WL_ADDR:
    - shadow winLoss takes cpu_data[1:0]; the value 11 is stored as 00;
    - set commit_pending.
  - cpu_addr = CLEAR_ADDR: go to CLEAR, cpu_busy=1 from the next cycle.
  - Any other address: ignored, no state change.
- FSM:
  - IDLE → CLEAR on a clear write.
  - CLEAR:
    - a 4-bit counter i runs 0..NUM_SLOTS-1, writing shadow[i]=BLANK_INDEX, one slot per cycle;
    - shadow winLoss is set to 00 on the first CLEAR cycle;
    - after i=NUM_SLOTS-1, return to IDLE and set commit_pending;
    - CLEAR lasts exactly NUM_SLOTS cycles.
  - In CLEAR, all cpu_wEn writes are dropped, including further clear writes.
- Commit:
  - On any cycle with screenEnd=1 and commit_pending=1 and state IDLE, the display bank (slots and winLoss) takes the shadow bank in one cycle and commit_pending clears.
  - screenEnd during CLEAR: no commit; the sweep completes and commits at the next screenEnd.
  - A write and screenEnd in the same cycle: the commit copies the pre-write shadow and commit_pending stays 1. The new value appears one frame later.
- Read path:
  - cardIndex is registered with 1-cycle latency from RAMaddr.
  - It reads the display bank only: zero-extended display[RAMaddr-BASE_ADDR].
  - RAMaddr outside the slot range returns BLANK_INDEX.
- winLoss output is the display-bank register; it changes only on commit or reset.
- Arithmetic:
  - slot offset = cpu_addr-BASE_ADDR, computed in 32 bits and range-checked before indexing (no wrap on addresses below BASE_ADDR);
  - each slot is stored as $clog2(SPRITE_COUNT) bits.

Decomposition:
- Shared package holds:
  - BASE_ADDR, WL_ADDR, CLEAR_ADDR, NUM_SLOTS, SPRITE_COUNT, BLANK_INDEX;
  - the winLoss encodings WL_NONE=00, WL_WIN=01, WL_LOSS=10;
  - the FSM state type {IDLE, CLEAR}.
- The VGA controller and the processor memory map import the same constants.
- One natural sub-module: `slot_bank`, a NUM_SLOTS-entry register array with one write port, a parallel load-from-other-bank input and one registered read port. It is instantiated twice, as shadow and display.

Test Plan:
- Reset, then RAMaddr=16..25 → cardIndex=13 for every slot one cycle after each address; winLoss=00; cpu_busy=0.
- Write addr 18 data 5 → commit_pending=1; RAMaddr=18 still reads 13 until the next screenEnd, then reads 5; commit_pending=0.
- Write addr 20 data 40 (out of range) and addr 26 data 3 → after commit, slot 4 reads 13 and winLoss=00. Then write addr 26 data 2 → after the next screenEnd, winLoss=10.
- Load slots with 1..10, commit, write addr 27 → cpu_busy high exactly 10 cycles; a write to addr 16 during busy is dropped; after the next screenEnd all slots read 13 and winLoss=00.
- Write addr 17 data 7 in the same cycle as screenEnd → slot 1 unchanged that frame; commit_pending stays 1; slot 1 reads 7 after the following screenEnd.
- Assert reset on cycle 4 of CLEAR with slots committed to 3 → next cycle: cpu_busy=0, all slots 13, winLoss=00, commit_pending=0. Also RAMaddr=15 and RAMaddr=26 → cardIndex=13.

Source files
------------

// File: rtl/card_frame_buffer_pkg.sv
// card_frame_buffer_pkg
//   Shared constants for the card display path: the processor memory map
//   (slot, win/loss and clear addresses), the sprite sheet geometry, the
//   win/loss encodings and the frame buffer state type. The VGA controller
//   and the processor memory map import the same definitions.
package card_frame_buffer_pkg;

    localparam int unsigned NUM_SLOTS    = 10;
    localparam int unsigned BASE_ADDR    = 16;
    localparam int unsigned WL_ADDR      = 26;
    localparam int unsigned CLEAR_ADDR   = 27;
    localparam int unsigned SPRITE_COUNT = 14;
    localparam int unsigned BLANK_INDEX  = 13;

    localparam int unsigned SLOT_W = $clog2(SPRITE_COUNT);
    localparam int unsigned IDX_W  = $clog2(NUM_SLOTS);

    localparam logic [1:0] WL_NONE = 2'b00;
    localparam logic [1:0] WL_WIN  = 2'b01;
    localparam logic [1:0] WL_LOSS = 2'b10;

    typedef enum logic {IDLE, CLEAR} state_t;

    typedef logic [SLOT_W-1:0] slot_t;

    // Out-of-sheet sprite numbers are shown as the card back.
    function automatic slot_t sanitizeSprite(input logic [31:0] d);
        return (d < SPRITE_COUNT) ? slot_t'(d) : slot_t'(BLANK_INDEX);
    endfunction

    // The unused encoding 11 collapses to "no result".
    function automatic logic [1:0] sanitizeWinLoss(input logic [1:0] v);
        return (v == 2'b11) ? WL_NONE : v;
    endfunction

endpackage

// File: rtl/card_frame_buffer_slot_bank.sv
// slot_bank
//   NUM-entry register array of W-bit slots.
//   clk, reset  : clock, synchronous active-high reset (all entries and the
//                 read register go to RESET_VAL)
//   wEn/wAddr/wData : single write port
//   load/loadData   : parallel load of all entries (wins over the write port)
//   bankData        : all entries, flattened, slot 0 in the low bits
//   rValid/rAddr/rData : registered read port; rData shows RESET_VAL when
//                        rValid is low
module slot_bank #(
    parameter int unsigned   NUM       = 10,
    parameter int unsigned   W         = 4,
    parameter int unsigned   IDXW      = 4,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wEn,
    input  logic [IDXW-1:0]   wAddr,
    input  logic [W-1:0]      wData,
    input  logic              load,
    input  logic [NUM*W-1:0]  loadData,
    output logic [NUM*W-1:0]  bankData,
    input  logic              rValid,
    input  logic [IDXW-1:0]   rAddr,
    output logic [W-1:0]      rData
);

    logic [NUM-1:0][W-1:0] mem;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem   <= {NUM{RESET_VAL}};
            rData <= RESET_VAL;
        end else begin
            if (load) begin
                mem <= loadData;
            end else if (wEn && (wAddr < IDXW'(NUM))) begin
                mem[wAddr] <= wData;
            end
            rData <= rValid ? mem[rAddr] : RESET_VAL;
        end
    end

    assign bankData = mem;

endmodule

// File: rtl/card_frame_buffer.sv
// card_frame_buffer
//   Double-buffered store of the ten on-screen card slots and the win/loss
//   flag. The processor writes a shadow bank; the shadow bank is copied to
//   the display bank only on a frame boundary so a hand update never tears.
//   A clear sequencer blanks all shadow slots, one per cycle.
//   clk, reset     : clock, synchronous active-high reset
//   cpu_wEn/cpu_addr/cpu_data : processor write port (memory mapped)
//   cpu_busy       : clear sequence running; writes are dropped
//   screenEnd      : one-cycle frame boundary pulse
//   RAMaddr        : slot read address from the VGA controller
//   cardIndex      : registered sprite index for RAMaddr (display bank)
//   winLoss        : committed win/loss state
//   commit_pending : shadow bank awaiting a frame boundary
module card_frame_buffer
    import card_frame_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wEn,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    output logic        cpu_busy,
    input  logic        screenEnd,
    input  logic [31:0] RAMaddr,
    output logic [31:0] cardIndex,
    output logic [1:0]  winLoss,
    output logic        commit_pending
);

    state_t              state;
    logic [IDX_W-1:0]    clrCnt;
    logic [1:0]          shadowWl;

    logic                idle;
    logic                slotHit;
    logic                rdHit;
    logic [IDX_W-1:0]    cpuIdx;
    logic [IDX_W-1:0]    rdIdx;
    logic                slotWr;
    logic                wlWr;
    logic                clrWr;
    logic                commit;

    logic                shWEn;
    logic [IDX_W-1:0]    shWAddr;
    slot_t               shWData;

    logic [NUM_SLOTS*SLOT_W-1:0] shadowData;
    logic [NUM_SLOTS*SLOT_W-1:0] unusedDisplayData;
    slot_t                       unusedShadowRd;
    slot_t                       dispRd;

    // Range checks are done on the full 32-bit address so addresses below
    // BASE_ADDR cannot wrap into the slot range.
    always_comb begin
        idle    = (state == IDLE);
        slotHit = (cpu_addr >= BASE_ADDR) && (cpu_addr < BASE_ADDR + NUM_SLOTS);
        rdHit   = (RAMaddr >= BASE_ADDR) && (RAMaddr < BASE_ADDR + NUM_SLOTS);
        cpuIdx  = IDX_W'(cpu_addr - BASE_ADDR);
        rdIdx   = IDX_W'(RAMaddr - BASE_ADDR);
        slotWr  = idle && cpu_wEn && slotHit;
        wlWr    = idle && cpu_wEn && (cpu_addr == WL_ADDR);
        clrWr   = idle && cpu_wEn && (cpu_addr == CLEAR_ADDR);
        commit  = idle && screenEnd && commit_pending;
    end

    // The shadow write port is shared by processor writes (IDLE) and the
    // clear sweep (CLEAR); the two never coincide.
    always_comb begin
        shWEn   = slotWr;
        shWAddr = cpuIdx;
        shWData = sanitizeSprite(cpu_data);
        if (state == CLEAR) begin
            shWEn   = 1'b1;
            shWAddr = clrCnt;
            shWData = slot_t'(BLANK_INDEX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            clrCnt         <= '0;
            shadowWl       <= WL_NONE;
            winLoss        <= WL_NONE;
            commit_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit) begin
                        winLoss <= shadowWl;
                    end
                    if (wlWr) begin
                        shadowWl <= sanitizeWinLoss(cpu_data[1:0]);
                    end
                    // A write in the commit cycle keeps the flag set: the
                    // commit copied the pre-write shadow.
                    if (slotWr || wlWr) begin
                        commit_pending <= 1'b1;
                    end else if (commit) begin
                        commit_pending <= 1'b0;
                    end
                    if (clrWr) begin
                        state  <= CLEAR;
                        clrCnt <= '0;
                    end
                end
                CLEAR: begin
                    shadowWl <= WL_NONE;
                    if (clrCnt == IDX_W'(NUM_SLOTS - 1)) begin
                        state          <= IDLE;
                        clrCnt         <= '0;
                        commit_pending <= 1'b1;
                    end else begin
                        clrCnt <= clrCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_busy  = (state == CLEAR);
    assign cardIndex = 32'(dispRd);

    slot_bank #(
        .NUM       (NUM_SLOTS),
        .W         (SLOT_W),
        .IDXW      (IDX_W),
        .RESET_VAL (slot_t'(BLANK_INDEX))
    ) shadowBank (
        .clk      (clk),
        .reset    (reset),
        .wEn      (shWEn),
        .wAddr    (shWAddr),
        .wData    (shWData),
        .load     (1'b0),
        .loadData ('0),
        .bankData (shadowData),
        .rValid   (1'b0),
        .rAddr    ('0),
        .rData    (unusedShadowRd)
    );

    slot_bank #(
        .NUM       (NUM_SLOTS),
        .W         (SLOT_W),
        .IDXW      (IDX_W),
        .RESET_VAL (slot_t'(BLANK_INDEX))
    ) displayBank (
        .clk      (clk),
        .reset    (reset),
        .wEn      (1'b0),
        .wAddr    ('0),
        .wData    ('0),
        .load     (commit),
        .loadData (shadowData),
        .bankData (unusedDisplayData),
        .rValid   (rdHit),
        .rAddr    (rdIdx),
        .rData    (dispRd)
    );

endmodule
